// File: rtl/demux4_buf_pkg.sv
// demux4_buf_pkg
//   Shared constants and helpers for the 4-channel demux/mux pair.
//   K_DEF    : default data width (matches Mux4/DFF default)
//   NCH      : channel count
//   ERRW_DEF : default width of the saturating select-error counter
//   is_onehot4(sel) : 1 iff exactly one bit of sel is set
package demux4_buf_pkg;

   localparam int unsigned K_DEF    = 16;
   localparam int unsigned NCH      = 4;
   localparam int unsigned ERRW_DEF = 8;

   typedef logic [NCH-1:0] ch_mask_t;

   // Clearing the lowest set bit leaves zero only for a single-bit pattern.
   function automatic logic is_onehot4(input logic [3:0] sel);
      return (sel != '0) && ((sel & (sel - 4'd1)) == '0);
   endfunction

endpackage

// File: rtl/demux4_buf_if.sv
// demux4_buf_if
//   Producer/consumer bus of the 4-channel registered demultiplexer.
//   Producer side : in_data, in_sel (one-hot), in_valid, in_ready
//   Consumer side : out_data0..3, out_valid[3:0], out_ready[3:0]
//   Status        : sel_err (1-cycle pulse), err_count (saturating)
//   Modports      : slave (the demux), master (producer/consumers/status)
interface demux4_buf_if #(
   parameter int unsigned K    = demux4_buf_pkg::K_DEF,
   parameter int unsigned ERRW = demux4_buf_pkg::ERRW_DEF
);

   logic [K-1:0]    in_data;
   logic [3:0]      in_sel;
   logic            in_valid;
   logic            in_ready;
   logic [K-1:0]    out_data3;
   logic [K-1:0]    out_data2;
   logic [K-1:0]    out_data1;
   logic [K-1:0]    out_data0;
   logic [3:0]      out_valid;
   logic [3:0]      out_ready;
   logic            sel_err;
   logic [ERRW-1:0] err_count;

   modport slave (
      input  in_data, in_sel, in_valid, out_ready,
      output in_ready, out_data3, out_data2, out_data1, out_data0,
             out_valid, sel_err, err_count
   );

   modport master (
      output in_data, in_sel, in_valid, out_ready,
      input  in_ready, out_data3, out_data2, out_data1, out_data0,
             out_valid, sel_err, err_count
   );

endinterface

// File: rtl/demux4_buf_slot.sv
// demux4_buf_slot
//   Single-entry valid/ready buffer for one demux channel.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en       : load wr_data (only asserted when slot_ready is high)
//   wr_data     : word to store
//   rd_ready    : consumer takes the stored word this cycle
//   data, valid : registered word and full flag
//   slot_ready  : slot can take a word this cycle (empty or draining)
module demux4_buf_slot #(
   parameter int unsigned K = demux4_buf_pkg::K_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [K-1:0] wr_data,
   input  logic         rd_ready,
   output logic [K-1:0] data,
   output logic         valid,
   output logic         slot_ready
);

   assign slot_ready = ~valid | rd_ready;

   // A write while full only happens together with a drain, so valid stays 1.
   // On a plain drain the data word is deliberately left stale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (wr_en) begin
         data  <= wr_data;
         valid <= 1'b1;
      end else if (rd_ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux4_buf.sv
// demux4_buf
//   4-channel registered demultiplexer: routes in_data to the channel picked
//   by a one-hot in_sel, each channel buffering one word behind valid/ready.
//   Words with an illegal select are discarded, flagged by a one-cycle
//   sel_err pulse and counted in a saturating err_count.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : demux4_buf_if.slave (producer, four consumers, error status)
module demux4_buf
   import demux4_buf_pkg::*;
#(
   parameter int unsigned K    = K_DEF,
   parameter int unsigned ERRW = ERRW_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   demux4_buf_if.slave  bus
);

   logic            legal;
   logic            bad_acc;
   ch_mask_t        wr_en;
   ch_mask_t        slot_ready;
   ch_mask_t        slot_valid;
   logic [K-1:0]    slot_data [NCH];
   logic            sel_err_q;
   logic [ERRW-1:0] err_count_q;

   assign legal = is_onehot4(bus.in_sel);

   // in_ready never looks at in_valid; an illegal select is always taken so
   // the producer cannot stall on it.
   always_comb begin
      bus.in_ready = 1'b1;
      if (legal) begin
         bus.in_ready = |(bus.in_sel & slot_ready);
      end
   end

   always_comb begin
      wr_en = '0;
      if (bus.in_valid && legal && bus.in_ready) begin
         wr_en = bus.in_sel;
      end
   end

   assign bad_acc = bus.in_valid & ~legal;

   for (genvar g = 0; g < NCH; g++) begin : g_slot
      demux4_buf_slot #(.K(K)) u_slot (
         .clk        (clk),
         .rst_n      (rst_n),
         .wr_en      (wr_en[g]),
         .wr_data    (bus.in_data),
         .rd_ready   (bus.out_ready[g]),
         .data       (slot_data[g]),
         .valid      (slot_valid[g]),
         .slot_ready (slot_ready[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err_q   <= 1'b0;
         err_count_q <= '0;
      end else begin
         sel_err_q <= bad_acc;
         if (bad_acc && (err_count_q != '1)) begin
            err_count_q <= err_count_q + ERRW'(1);
         end
      end
   end

   assign bus.out_data0 = slot_data[0];
   assign bus.out_data1 = slot_data[1];
   assign bus.out_data2 = slot_data[2];
   assign bus.out_data3 = slot_data[3];
   assign bus.out_valid = slot_valid;
   assign bus.sel_err   = sel_err_q;
   assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_demux4_buf.sv
// tb_demux4_buf
//   Scoreboard bench for demux4_buf. Two instances share one stimulus stream:
//   dut8 (ERRW=8) is fully checked, dut2 (ERRW=2) exercises counter saturation.
//   The driver predicts in_ready from per-channel expected-word queues and
//   pushes accepted words; the monitor pops a word on every DUT handshake.
module tb_demux4_buf;
   import demux4_buf_pkg::*;

   localparam int unsigned K = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   demux4_buf_if #(.K(K), .ERRW(8)) bus8 ();
   demux4_buf_if #(.K(K), .ERRW(2)) bus2 ();

   assign bus2.in_data   = bus8.in_data;
   assign bus2.in_sel    = bus8.in_sel;
   assign bus2.in_valid  = bus8.in_valid;
   assign bus2.out_ready = bus8.out_ready;

   demux4_buf #(.K(K), .ERRW(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   demux4_buf #(.K(K), .ERRW(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   typedef struct {
      logic        sel_err;
      int unsigned e8;
      int unsigned e2;
   } errexp_t;

   logic [K-1:0] expq [4][$];
   errexp_t      sq [$];
   int unsigned  e8_m = 0;
   int unsigned  e2_m = 0;
   int           passed = 0;
   int           total = 0;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endfunction

   function automatic logic [K-1:0] data_of(input int i);
      case (i)
         0:       return bus8.out_data0;
         1:       return bus8.out_data1;
         2:       return bus8.out_data2;
         default: return bus8.out_data3;
      endcase
   endfunction

   // One clock cycle of stimulus plus prediction.
   task automatic cyc(input bit v, input logic [3:0] sel, input logic [K-1:0] d,
                      input logic [3:0] ordy);
      bit legal;
      bit exp_rdy;
      int ch;
      @(posedge clk);
      #2;
      bus8.in_valid  = v;
      bus8.in_sel    = sel;
      bus8.in_data   = d;
      bus8.out_ready = ordy;
      #1;
      legal = ($countones(sel) == 1);
      ch = 0;
      for (int i = 0; i < 4; i++) if (sel[i]) ch = i;
      exp_rdy = legal ? ((expq[ch].size() == 0) || ordy[ch]) : 1'b1;
      chk("in_ready", {31'd0, bus8.in_ready}, {31'd0, exp_rdy});
      if (v && exp_rdy && legal) expq[ch].push_back(d);
      if (v && !legal) begin
         if (e8_m < 255) e8_m++;
         if (e2_m < 3) e2_m++;
      end
      sq.push_back('{sel_err: (v && !legal), e8: e8_m, e2: e2_m});
   endtask

   task automatic idle(input logic [3:0] ordy, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 4'($urandom), 16'($urandom), ordy);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_out_valid"}, {28'd0, bus8.out_valid}, 32'd0);
      chk({tag, "_out_data0"}, {16'd0, bus8.out_data0}, 32'd0);
      chk({tag, "_out_data1"}, {16'd0, bus8.out_data1}, 32'd0);
      chk({tag, "_out_data2"}, {16'd0, bus8.out_data2}, 32'd0);
      chk({tag, "_out_data3"}, {16'd0, bus8.out_data3}, 32'd0);
      chk({tag, "_sel_err"},   {31'd0, bus8.sel_err}, 32'd0);
      chk({tag, "_err_count"}, {24'd0, bus8.err_count}, 32'd0);
      chk({tag, "_err_count2"}, {30'd0, bus2.err_count}, 32'd0);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++) expq[i].delete();
      sq.delete();
      e8_m = 0;
      e2_m = 0;
   endtask

   // Monitor: pops on each handshake, checks occupancy and error status.
   initial begin
      logic [3:0]   occ;
      logic [K-1:0] w;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
               if (bus8.out_valid[i] && bus8.out_ready[i]) begin
                  if (expq[i].size() == 0) begin
                     chk($sformatf("out_valid%0d_spurious", i),
                         {31'd0, bus8.out_valid[i]}, 32'd0);
                  end else begin
                     w = expq[i].pop_front();
                     chk($sformatf("out_data%0d", i), {16'd0, data_of(i)}, {16'd0, w});
                  end
               end
            end
         end
         @(posedge clk);
         #1;
         if (rst_n === 1'b1) begin
            for (int i = 0; i < 4; i++) occ[i] = (expq[i].size() != 0);
            chk("out_valid", {28'd0, bus8.out_valid}, {28'd0, occ});
            if (sq.size() != 0) begin
               errexp_t e;
               e = sq.pop_front();
               chk("sel_err",    {31'd0, bus8.sel_err}, {31'd0, e.sel_err});
               chk("sel_err2",   {31'd0, bus2.sel_err}, {31'd0, e.sel_err});
               chk("err_count",  {24'd0, bus8.err_count}, e.e8);
               chk("err_count2", {30'd0, bus2.err_count}, e.e2);
            end
         end
      end
   end

   initial begin
      logic [3:0] s;
      rst_n = 1'b0;
      bus8.in_valid  = 1'b0;
      bus8.in_sel    = 4'b0100;
      bus8.in_data   = '0;
      bus8.out_ready = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      #2;
      rst_n = 1'b1;

      // Single route to channel 2
      cyc(1'b1, 4'b0100, 16'hBEEF, 4'b0000);
      idle(4'b0000, 1);
      chk("route_data2", {16'd0, bus8.out_data2}, 32'h0000BEEF);

      // Backpressure on channel 1
      cyc(1'b1, 4'b0010, 16'h1111, 4'b0000);
      cyc(1'b1, 4'b0010, 16'h2222, 4'b0000);
      cyc(1'b1, 4'b0010, 16'h2222, 4'b0010);
      idle(4'b0000, 1);

      // Streaming on channel 0
      for (int i = 1; i <= 10; i++) cyc(1'b1, 4'b0001, 16'(i), 4'b0001);
      idle(4'b0001, 1);

      // Illegal selects; ERRW=2 instance saturates on the 4th and 5th
      cyc(1'b1, 4'b0000, 16'hDEAD, 4'b0000);
      cyc(1'b1, 4'b0011, 16'hDEAD, 4'b0000);
      cyc(1'b1, 4'b1111, 16'hDEAD, 4'b0000);
      cyc(1'b1, 4'b0101, 16'hDEAD, 4'b0000);
      cyc(1'b1, 4'b1010, 16'hDEAD, 4'b0000);
      idle(4'b1111, 2);

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 4) == 0) s = 4'($urandom);
         else s = 4'(1 << $urandom_range(0, 3));
         cyc(($urandom_range(0, 9) < 7), s, 16'($urandom), 4'($urandom));
      end
      idle(4'b1111, 2);

      // Saturate the 8-bit counter
      for (int n = 0; n < 260; n++) begin
         do s = 4'($urandom); while ($countones(s) == 1);
         cyc(1'b1, s, 16'($urandom), 4'($urandom));
      end
      idle(4'b1111, 2);

      // Fill all channels, then reset asynchronously mid-cycle
      for (int i = 0; i < 4; i++) cyc(1'b1, 4'(1 << i), 16'hA000 + 16'(i), 4'b0000);
      idle(4'b0000, 1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      clear_model();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;

      // Normal route to channel 3 after release
      cyc(1'b1, 4'b1000, 16'hC0DE, 4'b0000);
      idle(4'b0000, 1);
      chk("post_reset_data3", {16'd0, bus8.out_data3}, 32'h0000C0DE);
      idle(4'b1111, 3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/demux4_buf.md
Name: demux4_buf

Overview:
- 4-channel registered demultiplexer; the write-side counterpart of the one-hot 4-channel mux.
- Routes one K-bit input word to one of four output channels, chosen by a one-hot select.
- Each channel holds one word in a single-entry buffer with a valid/ready handshake.
- Sits between the command sequencer, which produces words, and the four subsystem consumers, which are gathered back later through Mux4.

Parameters:
- K, 16, data width in bits (matches the Mux4/DFF default).
- ERRW, 8, width of the saturating select-error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  K  word to route.
- in_sel  in  4  one-hot channel select; bit i selects channel i.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts the word this cycle.
- out_data3, out_data2, out_data1, out_data0  out  K each  per-channel buffered word.
- out_valid  out  4  bit i: channel i buffer full.
- out_ready  in  4  bit i: consumer i takes the word this cycle.
- sel_err  out  1  one-cycle pulse: a word with an illegal select was discarded.
- err_count  out  ERRW  number of discarded words, saturating.

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - out_valid=0, all out_data=0, sel_err=0, err_count=0.
  - Buffered words are lost; any word in flight is not accepted.
  - Release is synchronous to the next clk edge.
- Select legality: legal iff exactly one bit of in_sel is set. 0000 and any pattern with two or more bits set are illegal.
- in_ready is combinational from in_sel, out_valid and out_ready only; it must never depend on in_valid.
  - Legal select on channel i: in_ready = ~out_valid[i] | out_ready[i].
  - Illegal select: in_ready = 1, so the producer never deadlocks.
- Accept: in_valid & in_ready at a rising edge.
- Legal accept on channel i:
  - Next edge: out_data_i <= in_data, out_valid[i] <= 1.
  - Latency is 1 cycle, input to out_valid.
- Drain on channel i: out_valid[i] & out_ready[i] with no write to i means out_valid[i] <= 0 next edge. out_data_i holds its stale value; it is not cleared.
- Simultaneous drain and write on the same channel: out_valid[i] stays 1 and out_data_i takes the new word. Full throughput is 1 word/cycle per channel.
- out_ready[i] while out_valid[i]=0 is ignored.
- Other channels are unaffected by any write or drain; all four channels may drain in the same cycle.
- Illegal accept:
  - Word discarded; no channel changes.
  - sel_err=1 for exactly the next cycle.
  - err_count increments and saturates at 2^ERRW-1 (no wrap).
  - Back-to-back illegal accepts hold sel_err high continuously.
- in_valid=0: no buffer writes and no error, whatever in_sel holds.
- Outputs out_valid, out_data, sel_err and err_count are driven directly from registers, with no combinational path from inputs.

Decomposition:
- Shared package (common_pkg): default K=16, channel count NCH=4, ERRW default, and a function is_onehot4(sel) returning the legality bit. This function is reused by the Mux4 callers for assertions.
- One natural sub-module, demux_slot:
  - Parameter K; ports clk, rst_n, wr_en, wr_data, rd_ready, data, valid, slot_ready.
  - Instantiated 4×.
  - slot_ready = ~valid | rd_ready.
- Top level holds the select decode, the error pulse and the counter.

Test Plan:
- Reset and single route: rst_n low for 2 cycles, then all outputs 0. Send in_sel=0100, in_data=16'hBEEF, in_valid=1 for 1 cycle → next cycle out_valid=0100, out_data2=BEEF, others unchanged.
- Backpressure: channel 1 full, out_ready=0000, drive in_sel=0010 with in_valid=1 → in_ready=0, word held by producer. Raise out_ready[1] → in_ready=1 the same cycle; next edge replaces out_data1, out_valid[1] stays 1.
- Streaming: channel 0, out_ready[0]=1 permanently, 10 consecutive words 0x0001..0x000A → one word per cycle, out_data0 sequence 1..A with 1-cycle lag, no bubbles.
- Illegal selects: in_sel=0000, then 0011, then 1111, each with in_valid=1 → in_ready=1 each cycle, sel_err high for 3 consecutive cycles, err_count=3, out_valid unchanged.
- Saturation with ERRW=2: five illegal accepts → err_count sequence 1,2,3,3,3.
- Reset mid-operation: all four channels full, assert rst_n asynchronously mid-cycle → out_valid=0000 immediately, before the next clk edge. After release, a normal route to channel 3 works.
